// File: rtl/procyon_core_pkg.sv
// procyon_core_pkg: core-wide geometry constants.
// No ports; provides the data-cache line offset width used to split byte
// addresses into line address and line offset.
package procyon_core_pkg;

  localparam int DC_LINE_SIZE    = 32;
  localparam int DC_OFFSET_WIDTH = procyon_lib_pkg::clog2(DC_LINE_SIZE);

endpackage

// File: rtl/procyon_lib_pkg.sv
// procyon_lib_pkg: generic helper functions shared across the procyon codebase.
// No ports; provides clog2() for sizing index and counter fields.
package procyon_lib_pkg;

  // Number of bits needed to index 'value' distinct items (0 for value <= 1).
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((32'sd1 <<< width) < value) begin
      width = width + 32'sd1;
    end
    return width;
  endfunction

endpackage

// File: rtl/procyon_ccu_linefill_asm.sv
// procyon_ccu_linefill_asm: beat counter plus cacheline assembly register.
// Each accepted beat is written into its little-endian slot of the line and
// the counter advances, wrapping to zero after the final beat.
// Ports: clk, rst (async, active-high), i_clear (zero the beat counter),
//        i_beat_valid / i_beat_data (incoming beat), o_last_beat (this beat
//        completes the line), o_line (assembled line).
module procyon_ccu_linefill_asm
  import procyon_lib_pkg::*;
#(
  parameter int BEAT_WIDTH = 32,
  parameter int NUM_BEATS  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_clear,
  input  logic                            i_beat_valid,
  input  logic [BEAT_WIDTH-1:0]           i_beat_data,
  output logic                            o_last_beat,
  output logic [BEAT_WIDTH*NUM_BEATS-1:0] o_line
);

  localparam int CNT_W  = clog2(NUM_BEATS);
  localparam int LINE_W = BEAT_WIDTH * NUM_BEATS;

  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [LINE_W-1:0] line_next_s;

  // Counter is a power-of-2 modulus, so the increment wraps to zero on its own.
  always_comb begin
    cnt_next_s = cnt_r;
    if (i_clear) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (i_beat_valid) begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Merge the incoming beat into its slot of the current line.
  always_comb begin
    line_next_s = o_line;
    line_next_s[cnt_r*BEAT_WIDTH +: BEAT_WIDTH] = i_beat_data;
  end

  assign o_last_beat = i_beat_valid & (cnt_r == CNT_W'(NUM_BEATS - 1));

  procyon_srff #(
    .WIDTH       (CNT_W),
    .RESET_VALUE ({CNT_W{1'b0}})
  ) cnt_ff (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (cnt_next_s),
    .o_q  (cnt_r)
  );

  procyon_ff #(
    .WIDTH (LINE_W)
  ) line_ff (
    .clk  (clk),
    .i_en (i_beat_valid),
    .i_d  (line_next_s),
    .o_q  (o_line)
  );

endmodule

// File: rtl/procyon_ff.sv
// procyon_ff: enabled datapath register without reset.
// Ports: clk, i_en (load enable), i_d (next value), o_q (registered value).
module procyon_ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Load on enable; contents are don't-care until first written.
  always_ff @(posedge clk) begin
    if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/procyon_srff.sv
// procyon_srff: enabled register with asynchronous active-high reset to a
// parameterised value.
// Ports: clk, rst (async, active-high), i_en (load enable), i_d (next value),
//        o_q (registered value).
module procyon_srff #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Load on enable, force the reset value asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= RESET_VALUE;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/procyon_ccu_linefill.sv
// procyon_ccu_linefill: fetches one cacheline from the bus interface on behalf
// of a miss handling queue (MHQ) entry. One fill is outstanding at a time.
// Ports:
//   clk, rst                       clock, async active-high reset
//   i_mhq_req_valid/idx/addr       fill request (line address)
//   o_mhq_req_ready                high only while idle
//   o_biu_en, o_biu_addr           bus read request, line-aligned byte address
//   i_biu_ack                      bus accepted the read
//   i_biu_data_valid, i_biu_data   returning beats, lowest beat first
//   o_ccu_done/idx/data            one-cycle completion pulse with the line
module procyon_ccu_linefill
  import procyon_lib_pkg::*;
  import procyon_core_pkg::*;
#(
  parameter int  OPTN_ADDR_WIDTH    = 32,
  parameter int  OPTN_DC_LINE_SIZE  = 32,
  parameter int  OPTN_BIU_DATA_SIZE = 4,
  parameter int  OPTN_MHQ_DEPTH     = 4,
  localparam int MHQ_IDX_WIDTH      = clog2(OPTN_MHQ_DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_mhq_req_valid,
  input  logic [MHQ_IDX_WIDTH-1:0]               i_mhq_req_idx,
  input  logic [OPTN_ADDR_WIDTH-DC_OFFSET_WIDTH-1:0] i_mhq_req_addr,
  output logic                                   o_mhq_req_ready,
  output logic                                   o_biu_en,
  output logic [OPTN_ADDR_WIDTH-1:0]             o_biu_addr,
  input  logic                                   i_biu_ack,
  input  logic                                   i_biu_data_valid,
  input  logic [8*OPTN_BIU_DATA_SIZE-1:0]        i_biu_data,
  output logic                                   o_ccu_done,
  output logic [MHQ_IDX_WIDTH-1:0]               o_ccu_idx,
  output logic [8*OPTN_DC_LINE_SIZE-1:0]         o_ccu_data
);

  localparam int BIU_W       = 8 * OPTN_BIU_DATA_SIZE;
  localparam int NUM_BEATS   = OPTN_DC_LINE_SIZE / OPTN_BIU_DATA_SIZE;
  localparam int LINE_ADDR_W = OPTN_ADDR_WIDTH - DC_OFFSET_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DATA = 2'b10,
    DONE = 2'b11
  } state_t;

  logic [1:0]             state_r;
  state_t                 state_s;
  state_t                 state_next_s;
  logic                   accept_s;
  logic                   ack_s;
  logic                   beat_valid_s;
  logic                   last_beat_s;
  logic [LINE_ADDR_W-1:0] addr_r;

  assign state_s      = state_t'(state_r);
  assign accept_s     = (state_s == IDLE) & i_mhq_req_valid;
  assign ack_s        = (state_s == REQ) & i_biu_ack;
  // Beats outside DATA (including the ack cycle) never reach the assembler.
  assign beat_valid_s = (state_s == DATA) & i_biu_data_valid;

  // Next-state selection for the fill sequence.
  always_comb begin
    state_next_s = state_s;
    case (state_s)
      IDLE: begin
        if (i_mhq_req_valid) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (i_biu_ack) begin
          state_next_s = DATA;
        end else begin
          state_next_s = REQ;
        end
      end
      DATA: begin
        if (last_beat_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DATA;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  procyon_srff #(
    .WIDTH       (2),
    .RESET_VALUE (2'b00)
  ) state_ff (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (state_next_s),
    .o_q  (state_r)
  );

  // Control outputs are decoded from the next state so they arrive registered
  // and aligned with the state they describe.
  procyon_srff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) ready_ff (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (state_next_s == IDLE),
    .o_q  (o_mhq_req_ready)
  );

  procyon_srff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) biu_en_ff (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (state_next_s == REQ),
    .o_q  (o_biu_en)
  );

  procyon_srff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) done_ff (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (state_next_s == DONE),
    .o_q  (o_ccu_done)
  );

  procyon_ff #(
    .WIDTH (MHQ_IDX_WIDTH)
  ) idx_ff (
    .clk  (clk),
    .i_en (accept_s),
    .i_d  (i_mhq_req_idx),
    .o_q  (o_ccu_idx)
  );

  procyon_ff #(
    .WIDTH (LINE_ADDR_W)
  ) addr_ff (
    .clk  (clk),
    .i_en (accept_s),
    .i_d  (i_mhq_req_addr),
    .o_q  (addr_r)
  );

  assign o_biu_addr = {addr_r, {DC_OFFSET_WIDTH{1'b0}}};

  procyon_ccu_linefill_asm #(
    .BEAT_WIDTH (BIU_W),
    .NUM_BEATS  (NUM_BEATS)
  ) asm_inst (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (ack_s),
    .i_beat_valid (beat_valid_s),
    .i_beat_data  (i_biu_data),
    .o_last_beat  (last_beat_s),
    .o_line       (o_ccu_data)
  );

endmodule
